// File: rtl/ble_hamming_payload_decoder_p_if.sv
`default_nettype none
// ============================================================================
// Module   : ble_hamming_payload_decoder_p_if
// Brief    : Frame control, coded-bit input and decoded-bit output bundle
// Revision : 1.0
// ============================================================================
interface ble_hamming_payload_decoder_p_if #(
  parameter int CNT_W  = 16,
  parameter int STAT_W = 8
);
  logic              start;
  logic [CNT_W-1:0]  n_bits;
  logic              corr_en;
  logic              data_in;
  logic              valid_in;
  logic              data_out;
  logic              valid_out;
  logic              decoded;
  logic [STAT_W-1:0] corr_count;
  logic [STAT_W-1:0] uncorr_count;
  logic              short_drop;
  logic              busy;
  logic              finished;

  modport master (
    output start, n_bits, corr_en, data_in, valid_in,
    input  data_out, valid_out, decoded, corr_count, uncorr_count,
           short_drop, busy, finished
  );

  modport slave (
    input  start, n_bits, corr_en, data_in, valid_in,
    output data_out, valid_out, decoded, corr_count, uncorr_count,
           short_drop, busy, finished
  );
endinterface
`default_nettype wire

// File: rtl/ble_hamming_payload_decoder_p.sv
`default_nettype none
// ============================================================================
// Module   : ble_hamming_payload_decoder_p
// Brief    : Serial Hamming(2^M-1) payload decoder with shortened final block
// Revision : 1.0
// ============================================================================
module ble_hamming_payload_decoder_p #(
  parameter int M      = 4,
  parameter int CNT_W  = 16,
  parameter int STAT_W = 8
) (
  input  logic clk,
  input  logic reset,
  ble_hamming_payload_decoder_p_if.slave bus
);
  localparam int N   = (1 << M) - 1;
  localparam int K   = N - M;
  localparam int OCW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_nbits, r_total;
  logic              r_corr_en;
  logic [N:1]        r_coll;
  logic [M-1:0]      r_pos, r_len;
  logic              r_pend, r_last;
  logic [K-1:0]      r_osh;
  logic [OCW-1:0]    r_ocnt;
  logic              r_decoded, r_short_drop, r_busy;
  logic [STAT_W-1:0] r_corr_cnt, r_uncorr_cnt;

  logic [M-1:0]      w_syn;
  logic [N:1]        w_fix;
  logic [K-1:0]      w_dat;
  logic [OCW-1:0]    w_dcnt;
  logic              w_hit, w_unc, w_drop, w_out_free, w_close;
  logic              w_accept, w_xfer, w_drop_now, w_finished;

  // The collector is read here on the transfer edge while a new block may
  // already be writing position 1, which is what makes it a ping-pong pair
  // together with the output shift register.
  always_comb begin
    w_syn = '0;
    w_fix = '0;
    for (int i = 1; i <= N; i++) begin
      if (i <= int'(r_len)) begin
        w_fix[i] = r_coll[i];
        if (r_coll[i]) w_syn = w_syn ^ M'(i);
      end
    end
    w_hit = r_corr_en && (w_syn != '0) && (w_syn <= r_len);
    w_unc = r_corr_en && (w_syn > r_len);
    if (w_hit) w_fix[w_syn] = ~w_fix[w_syn];
    w_dat  = '0;
    w_dcnt = '0;
    for (int i = 1; i <= N; i++) begin
      if (((i & (i - 1)) != 0) && (i <= int'(r_len))) begin
        w_dat[w_dcnt] = w_fix[i];
        w_dcnt        = w_dcnt + OCW'(1);
      end
    end
  end

  assign w_drop     = (w_dcnt == '0);
  assign w_out_free = (r_ocnt <= OCW'(1));
  assign w_close    = w_accept &&
                      ((r_pos + M'(1) == M'(N)) || (r_total + CNT_W'(1) == r_nbits));

  always_comb begin
    w_state_nx = r_state;
    w_accept   = 1'b0;
    w_xfer     = 1'b0;
    w_drop_now = 1'b0;
    w_finished = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nx = (bus.n_bits == '0) ? S_FLUSH : S_COLLECT;
      end
      S_COLLECT: begin
        w_accept = bus.valid_in && (r_total != r_nbits);
        if (r_pend) begin
          if (w_drop) begin
            w_drop_now = 1'b1;
            w_state_nx = S_FLUSH;
          end else if (w_out_free) begin
            w_xfer = 1'b1;
            if (r_last) w_state_nx = S_FLUSH;
          end else begin
            w_state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_out_free) begin
          w_xfer     = 1'b1;
          w_state_nx = r_last ? S_FLUSH : S_COLLECT;
        end
      end
      S_FLUSH: begin
        if (r_ocnt == '0) begin
          w_finished = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_nbits      <= '0;
      r_total      <= '0;
      r_corr_en    <= 1'b0;
      r_coll       <= '0;
      r_pos        <= '0;
      r_len        <= '0;
      r_pend       <= 1'b0;
      r_last       <= 1'b0;
      r_osh        <= '0;
      r_ocnt       <= '0;
      r_decoded    <= 1'b0;
      r_short_drop <= 1'b0;
      r_busy       <= 1'b0;
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_IDLE && bus.start) begin
        r_nbits      <= bus.n_bits;
        r_corr_en    <= bus.corr_en;
        r_total      <= '0;
        r_pos        <= '0;
        r_pend       <= 1'b0;
        r_short_drop <= 1'b0;
        r_busy       <= 1'b1;
        r_corr_cnt   <= '0;
        r_uncorr_cnt <= '0;
      end
      if (r_state == S_COLLECT && r_pend) r_pend <= 1'b0;
      if (w_accept) begin
        r_coll[r_pos + M'(1)] <= bus.data_in;
        r_total               <= r_total + CNT_W'(1);
        if (w_close) begin
          r_pend <= 1'b1;
          r_len  <= r_pos + M'(1);
          r_last <= (r_total + CNT_W'(1) == r_nbits);
          r_pos  <= '0;
        end else begin
          r_pos  <= r_pos + M'(1);
        end
      end
      r_decoded <= w_xfer && (w_syn != '0);
      if (w_xfer) begin
        r_osh  <= w_dat;
        r_ocnt <= w_dcnt;
        if (w_hit && r_corr_cnt != '1)   r_corr_cnt   <= r_corr_cnt + STAT_W'(1);
        if (w_unc && r_uncorr_cnt != '1) r_uncorr_cnt <= r_uncorr_cnt + STAT_W'(1);
      end else if (r_ocnt != '0) begin
        r_osh  <= r_osh >> 1;
        r_ocnt <= r_ocnt - OCW'(1);
      end
      if (w_drop_now) r_short_drop <= 1'b1;
      if (w_finished) r_busy <= 1'b0;
    end
  end

  assign bus.data_out     = r_osh[0];
  assign bus.valid_out    = (r_ocnt != '0);
  assign bus.decoded      = r_decoded;
  assign bus.corr_count   = r_corr_cnt;
  assign bus.uncorr_count = r_uncorr_cnt;
  assign bus.short_drop   = r_short_drop;
  assign bus.busy         = r_busy;
  assign bus.finished     = w_finished;
endmodule
`default_nettype wire

// File: tb/tb_ble_hamming_payload_decoder_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_ble_hamming_payload_decoder_p
// Brief    : Directed frames against a block-level Hamming model, M=4
// Revision : 1.0
// ============================================================================
module tb_ble_hamming_payload_decoder_p;
  localparam int N = 15;
  localparam int K = 11;
  typedef bit [15:1] blk_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ble_hamming_payload_decoder_p_if #(.CNT_W(16), .STAT_W(8)) bus ();
  ble_hamming_payload_decoder_p #(.M(4), .CNT_W(16), .STAT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0, checks = 0;
  int cyc = 0;
  bit exp_q[$];
  bit fbits[$];
  int exp_corr, exp_unc, exp_dec, exp_bits;
  bit exp_drop;
  int fin_cnt, dec_cnt, vo_cnt, first_vo_cyc, last_vo_cyc, fin_cyc;
  int start_cyc, drv_cyc, cur_nbits;
  logic [31:0] out_all;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic blk_t encode(input logic [31:0] d, input int len);
    blk_t b;
    int   j;
    bit   par;
    b = '0;
    j = 0;
    for (int p = 1; p <= len; p++)
      if ((p & (p - 1)) != 0) begin b[p] = d[j]; j++; end
    for (int p = 1; p <= len; p = p * 2) begin
      par = 1'b0;
      for (int q = 1; q <= len; q++)
        if (((q & (q - 1)) != 0) && ((q & p) != 0)) par ^= b[q];
      b[p] = par;
    end
    return b;
  endfunction

  function automatic void model_block(input blk_t rx, input int len, input bit cen);
    blk_t b;
    int   s;
    b = rx;
    s = 0;
    if (len < 3) begin exp_drop = 1'b1; return; end
    for (int p = 1; p <= len; p++) if (b[p]) s ^= p;
    if (s != 0) exp_dec++;
    if (cen && s != 0 && s <= len) begin b[s] = ~b[s]; exp_corr++; end
    else if (cen && s > len) exp_unc++;
    for (int p = 1; p <= len; p++) if ((p & (p - 1)) != 0) exp_q.push_back(b[p]);
  endfunction

  task automatic build(input int nbits, input bit cen, input logic [31:0] d0,
                       input logic [31:0] d1, input int f0, input int f1, input int f2);
    blk_t b;
    int   len, nb;
    fbits.delete();
    exp_q.delete();
    exp_corr = 0; exp_unc = 0; exp_dec = 0; exp_drop = 1'b0;
    nb = (nbits + N - 1) / N;
    for (int k = 0; k < nb; k++) begin
      len = (nbits - k * N > N) ? N : nbits - k * N;
      b   = encode((k == 0) ? d0 : d1, len);
      for (int p = 1; p <= len; p++) fbits.push_back(b[p]);
    end
    if (f0 > 0) fbits[f0 - 1] = ~fbits[f0 - 1];
    if (f1 > 0) fbits[f1 - 1] = ~fbits[f1 - 1];
    if (f2 > 0) fbits[f2 - 1] = ~fbits[f2 - 1];
    for (int k = 0; k < nb; k++) begin
      len = (nbits - k * N > N) ? N : nbits - k * N;
      b   = '0;
      for (int p = 1; p <= len; p++) b[p] = fbits[k * N + p - 1];
      model_block(b, len, cen);
    end
    exp_bits = exp_q.size();
  endtask

  // Called 1 time unit after a rising edge.
  task automatic start_frame(input int nbits, input bit cen);
    fin_cnt = 0; dec_cnt = 0; vo_cnt = 0; first_vo_cyc = -1; out_all = '0;
    cur_nbits   = nbits;
    bus.start   = 1'b1;
    bus.n_bits  = 16'(nbits);
    bus.corr_en = cen;
    start_cyc   = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1);
  endtask

  task automatic drive_bits(input int cnt, input bit poke);
    for (int i = 0; i < cnt; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = fbits[i];
      if (i == N - 1) drv_cyc = cyc;
      if (poke && i == 5) begin
        bus.start   = 1'b1;
        bus.n_bits  = '0;
        bus.corr_en = ~bus.corr_en;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
  endtask

  task automatic finish_check(input int lit_bits, input int lit_corr, input int lit_unc,
                              input int lit_dec, input bit lit_drop, input logic [31:0] lit_out);
    logic [31:0] mask;
    for (int w = 0; w < 400 && fin_cnt == 0; w++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    mask = (lit_bits >= 32) ? '1 : ((32'd1 << lit_bits) - 32'd1);
    chk("finished_pulses", fin_cnt, 1);
    chk("bits_out_model", vo_cnt, exp_bits);
    chk("bits_out_lit", vo_cnt, lit_bits);
    if (lit_bits > 0) chk("data_lit", out_all & mask, lit_out);
    chk("corr_count_model", bus.corr_count, exp_corr);
    chk("corr_count_lit", bus.corr_count, lit_corr);
    chk("uncorr_count_model", bus.uncorr_count, exp_unc);
    chk("uncorr_count_lit", bus.uncorr_count, lit_unc);
    chk("decoded_model", dec_cnt, exp_dec);
    chk("decoded_lit", dec_cnt, lit_dec);
    chk("short_drop_model", bus.short_drop, exp_drop);
    chk("short_drop_lit", bus.short_drop, lit_drop);
    chk("busy_cleared", bus.busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    if (exp_bits > 0) chk("finish_latency", fin_cyc, last_vo_cyc + 1);
    else              chk("finish_latency", fin_cyc, start_cyc + 1);
    if (cur_nbits >= N) chk("first_out_latency", first_vo_cyc, drv_cyc + 2);
  endtask

  // Output comparison against the model queue on every sampled cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.valid_out) begin
        if (vo_cnt < 32) out_all[vo_cnt] = bus.data_out;
        if (first_vo_cyc < 0) first_vo_cyc = cyc;
        last_vo_cyc = cyc;
        vo_cnt++;
        if (exp_q.size() == 0) chk("unexpected_valid_out", 1, 0);
        else begin
          bit e;
          e = exp_q.pop_front();
          chk("data_out", bus.data_out, e);
        end
      end
      if (bus.decoded) dec_cnt++;
      if (bus.finished) begin
        fin_cnt++;
        fin_cyc = cyc;
        chk("finish_with_pending_bits", exp_q.size(), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.n_bits   = '0;
    bus.corr_en  = 1'b0;
    bus.data_in  = 1'b0;
    bus.valid_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid_out", bus.valid_out, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_finished", bus.finished, 0);
    chk("reset_corr_count", bus.corr_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean 30-bit frame, with a second start injected mid-frame.
    build(30, 1'b1, 32'h5A3, 32'h0F1, 0, 0, 0);
    start_frame(30, 1'b1); drive_bits(30, 1'b1);
    finish_check(22, 0, 0, 0, 1'b0, 32'h78DA3);

    build(30, 1'b1, 32'h5A3, 32'h0F1, 5, 0, 0);
    start_frame(30, 1'b1); drive_bits(30, 1'b0);
    finish_check(22, 1, 0, 1, 1'b0, 32'h78DA3);

    build(30, 1'b0, 32'h5A3, 32'h0F1, 5, 0, 0);
    start_frame(30, 1'b0); drive_bits(30, 1'b0);
    finish_check(22, 0, 0, 1, 1'b0, 32'h78DA1);

    build(20, 1'b1, 32'h0F1, 32'h2, 0, 0, 0);
    start_frame(20, 1'b1); drive_bits(20, 1'b0);
    finish_check(13, 0, 0, 0, 1'b0, 32'h10F1);

    build(20, 1'b1, 32'h0F1, 32'h2, 18, 0, 0);
    start_frame(20, 1'b1); drive_bits(20, 1'b0);
    finish_check(13, 1, 0, 1, 1'b0, 32'h10F1);

    // Short-block syndrome 3^4=7 points beyond L=5.
    build(20, 1'b1, 32'h0F1, 32'h2, 18, 19, 0);
    start_frame(20, 1'b1); drive_bits(20, 1'b0);
    finish_check(13, 0, 1, 1, 1'b0, 32'h18F1);

    build(17, 1'b1, 32'h5A3, 32'h0, 0, 0, 0);
    start_frame(17, 1'b1); drive_bits(17, 1'b0);
    finish_check(11, 0, 0, 0, 1'b1, 32'h5A3);

    build(0, 1'b1, 32'h0, 32'h0, 0, 0, 0);
    start_frame(0, 1'b1);
    finish_check(0, 0, 0, 0, 1'b0, 32'h0);

    // Abort mid block 2 with reset.
    build(30, 1'b1, 32'h5A3, 32'h0F1, 5, 0, 0);
    start_frame(30, 1'b1); drive_bits(20, 1'b0);
    chk("pre_reset_corr_count", bus.corr_count, 1);
    chk("pre_reset_valid_out", bus.valid_out, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_valid_out", bus.valid_out, 0);
    chk("abort_data_out", bus.data_out, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_corr_count", bus.corr_count, 0);
    chk("abort_decoded", bus.decoded, 0);
    chk("abort_finished", bus.finished, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_finish", fin_cnt, 0);

    build(30, 1'b1, 32'h5A3, 32'h0F1, 0, 0, 0);
    start_frame(30, 1'b1); drive_bits(30, 1'b0);
    finish_check(22, 0, 0, 0, 1'b0, 32'h78DA3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
